conv_kxk: RTL

- Parametrised KxK multi-channel convolution engine. Successor to the fixed 3x3 RGB `conv` block.
- Consumes one pre-assembled KxK pixel window per beat and emits one filtered pixel per beat.
- Adds generic kernel size, channel count and data width, signed coefficients, shift normalisation, a clamp/absolute mode and full valid/ready backpressure through a 3-stage pipeline.
- Sits between the window/line-buffer stage and downstream colour/edge analysis.

---
 rtl/conv_kxk.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/conv_kxk.sv
// conv_kxk - parametrised KxK multi-channel convolution engine.
//
// Takes one KxK window per beat and produces one filtered pixel per beat. The
// window is multiplied by a signed kernel, summed per channel, shifted right
// and clamped (or rectified) back to DW bits. There are three pipeline stages
// with full valid/ready flow control, and empty stages collapse out of the way.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous reset, active low
//   en      in   input enable; when 0, no new beat is accepted
//   mode    in   0 = clamp to [0, 2^DW-1]; 1 = |y|, then clamp to 2^DW-1
//   s_data  in   window; pixel (r,c) channel ch at [((r*K+c)*CH+ch)*DW +: DW]
//   s_vld   in   input beat valid
//   s_rdy   out  input ready
//   m_data  out  filtered pixel; channel ch at [ch*DW +: DW]
//   m_vld   out  output valid
//   m_rdy   in   output ready
module conv_kxk #(
   parameter int                 K      = 3,
   parameter int                 CH     = 3,
   parameter int                 DW     = 8,
   parameter int                 CW     = 4,
   parameter logic [K*K*CW-1:0]  KERNEL = {4'd1, 4'd2, 4'd1,
                                           4'd2, 4'd4, 4'd2,
                                           4'd1, 4'd2, 4'd1},
   parameter int                 SHIFT  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  mode,
   input  logic [K*K*CH*DW-1:0]  s_data,
   input  logic                  s_vld,
   output logic                  s_rdy,
   output logic [CH*DW-1:0]      m_data,
   output logic                  m_vld,
   input  logic                  m_rdy
);
   localparam int NP = K * K;                       // taps per channel
   localparam int PW = DW + 1 + CW;                 // product width (pixel gets a sign bit)
   localparam int AW = DW + CW + $clog2(NP) + 1;    // accumulator width, no overflow possible
   localparam logic signed [AW-1:0] MAXV = $signed({{(AW-DW){1'b0}}, {DW{1'b1}}});

   // ------------------------------------------------------------------
   // Flow control. Each stage loads when it is empty or when the next stage
   // loads, so bubbles collapse even while the output is stalled.
   // ------------------------------------------------------------------
   logic r_v1;
   logic r_v2;
   logic r_m_vld;
   logic [CH*DW-1:0] r_m_data;
   logic w_ld1;
   logic w_ld2;
   logic w_ld3;
   logic w_acc;

   assign w_ld3 = !r_m_vld || m_rdy;
   assign w_ld2 = !r_v2 || w_ld3;
   assign w_ld1 = !r_v1 || w_ld2;
   assign s_rdy = en && rst && w_ld1;
   assign w_acc = s_vld && s_rdy;

   logic [NP*CH*PW-1:0] w_prod_flat;
   logic [CH*AW-1:0]    w_sum_flat;
   logic [CH*DW-1:0]    w_norm_flat;

   // ------------------------------------------------------------------
   // Stage 1: one signed product per tap and channel.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NP; gi++) begin : g_tap
      for (genvar gc = 0; gc < CH; gc++) begin : g_ch
         logic signed [PW-1:0] w_pix;
         logic signed [PW-1:0] w_coef;
         logic signed [PW-1:0] r_prod;

         // Pixels are unsigned, so zero-extend them. Coefficients are signed,
         // so sign-extend them.
         assign w_pix  = {{(CW+1){1'b0}}, s_data[(gi*CH+gc)*DW +: DW]};
         assign w_coef = PW'($signed(KERNEL[gi*CW +: CW]));

         always_ff @(posedge clk) begin
            if (w_acc) begin
               r_prod <= w_pix * w_coef;
            end
         end

         assign w_prod_flat[(gi*CH+gc)*PW +: PW] = r_prod;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: per-channel sum of all taps.
   // Stage 3 datapath: shift, rectify and saturate.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      logic signed [AW-1:0] w_sum;
      logic signed [AW-1:0] r_sum;
      logic signed [AW-1:0] w_y;
      logic signed [AW-1:0] w_sel;
      logic [DW-1:0]        w_px;

      always_comb begin
         w_sum = '0;
         for (int i = 0; i < NP; i++) begin
            w_sum = w_sum + AW'($signed(w_prod_flat[(i*CH+gi)*PW +: PW]));
         end
      end

      always_ff @(posedge clk) begin
         if (w_ld2 && r_v1) begin
            r_sum <= w_sum;
         end
      end

      assign w_sum_flat[gi*AW +: AW] = r_sum;

      // The arithmetic shift floors toward minus infinity.
      assign w_y = r_sum >>> SHIFT;

      // In mode 1 a negative value is negated first. After that, any value
      // that is still negative can only come from mode 0, and it becomes 0.
      always_comb begin
         w_sel = w_y;
         if (mode && w_y[AW-1]) begin
            w_sel = -w_y;
         end
         if (w_sel[AW-1]) begin
            w_px = '0;
         end else if (w_sel > MAXV) begin
            w_px = '1;
         end else begin
            w_px = w_sel[DW-1:0];
         end
      end

      assign w_norm_flat[gi*DW +: DW] = w_px;
   end

   // ------------------------------------------------------------------
   // Valid bits and the output register. mode is sampled here, when the
   // beat enters the last stage.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_m_vld  <= 1'b0;
         r_m_data <= '0;
      end else begin
         if (w_ld1) begin
            r_v1 <= w_acc;
         end
         if (w_ld2) begin
            r_v2 <= r_v1;
         end
         if (w_ld3) begin
            r_m_vld <= r_v2;
            if (r_v2) begin
               r_m_data <= w_norm_flat;
            end
         end
      end
   end

   assign m_vld  = r_m_vld;
   assign m_data = r_m_data;

   // w_sum_flat is not read anywhere else; this keeps it observable during debug.
   logic w_unused;
   assign w_unused = ^w_sum_flat;

endmodule
